// File: rtl/tag_search_ctrl.sv
// rtl/tag_search_ctrl.sv - sequential tag table search around an external 4-bit equality comparator
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   wr_en/wr_idx/wr_tag   write a tag entry and set its valid bit
//   clr_en/clr_idx        clear the valid bit of one entry (wins over a same-index write)
//   srch_valid/srch_key   search request, accepted when srch_ready is high
//   srch_ready            engine idle and able to accept a request
//   cmp_a/cmp_b           registered key/tag driven to the comparator
//   cmp_eq                comparator equality status
//   res_valid/res_hit/res_idx  result, held until res_ready
//   res_ready             result consumed
module tag_search_ctrl #(
  parameter int DEPTH = 8,
  parameter int IDXW  = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_en,
  input  logic [IDXW-1:0] wr_idx,
  input  logic [3:0]      wr_tag,
  input  logic            clr_en,
  input  logic [IDXW-1:0] clr_idx,
  input  logic            srch_valid,
  input  logic [3:0]      srch_key,
  output logic            srch_ready,
  output logic [3:0]      cmp_a,
  output logic [3:0]      cmp_b,
  input  logic            cmp_eq,
  output logic            res_valid,
  output logic            res_hit,
  output logic [IDXW-1:0] res_idx,
  input  logic            res_ready
);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  localparam logic [IDXW-1:0] LAST = IDXW'(DEPTH - 1);

  state_t          state;
  state_t          state_nxt;
  logic [IDXW-1:0] ptr;
  logic [3:0]      key;
  logic [3:0]      tags [DEPTH];
  logic [DEPTH-1:0] valid;
  logic            hit;
  logic            last;

  // Invalid entries are still scanned so latency depends only on the hit position.
  assign hit  = cmp_eq && valid[ptr];
  assign last = (ptr == LAST);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (srch_valid) state_nxt = DRIVE;
      DRIVE:   state_nxt = SAMPLE;
      SAMPLE:  state_nxt = (hit || last) ? DONE : DRIVE;
      DONE:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    srch_ready = (state == IDLE);
  end

  // Scan datapath and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr       <= '0;
      key       <= '0;
      cmp_a     <= '0;
      cmp_b     <= '0;
      res_valid <= 1'b0;
      res_hit   <= 1'b0;
      res_idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (srch_valid) begin
            key <= srch_key;
            ptr <= '0;
          end
        end
        DRIVE: begin
          cmp_a <= key;
          cmp_b <= tags[ptr];
        end
        SAMPLE: begin
          if (hit) begin
            res_hit   <= 1'b1;
            res_idx   <= ptr;
            res_valid <= 1'b1;
          end else if (last) begin
            res_hit   <= 1'b0;
            res_idx   <= '0;
            res_valid <= 1'b1;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        DONE: begin
          if (res_ready) res_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Tag table: clear is applied after the write so it wins on a shared index.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) tags[i] <= '0;
      valid <= '0;
    end else begin
      if (wr_en) begin
        tags[wr_idx]  <= wr_tag;
        valid[wr_idx] <= 1'b1;
      end
      if (clr_en) valid[clr_idx] <= 1'b0;
    end
  end

endmodule
